// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: screen geometry, coordinate widths and the
// page-flip controller state encoding.
package fb_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 9;
  localparam int PIX_W    = 8;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    DRAW    = 2'd1,
    WAIT_VB = 2'd2,
    FLIP    = 2'd3
  } page_state_t;

  function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/fb_sweep_counter.sv
// Raster x/y counter for the back-page clear: advances on en, wraps x at the
// line end and both axes after the last pixel, flags the last pixel.
module fb_sweep_counter
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/page_flip_ctrl.sv
// Double-buffer sequencer: clear back page, grant draw engine, wait for vblank,
// flip PAGE_SEL. Macro FB_CLEAR_EN enables the back-page clear sweep.
module page_flip_ctrl
  import fb_pkg::*;
#(
  parameter logic [PIX_W-1:0] BG_COLOR = 8'h00
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             VBLANK,
  input  logic             DRAW_REQ,
  input  logic [X_W-1:0]   DRAW_X,
  input  logic [Y_W-1:0]   DRAW_Y,
  input  logic [PIX_W-1:0] DRAW_PIXEL,
  input  logic             DRAW_DONE,
  output logic             DRAW_GNT,
  output logic             FRAME_START,
  output logic             WE,
  output logic [X_W-1:0]   PIXEL_X,
  output logic [Y_W-1:0]   PIXEL_Y,
  output logic [PIX_W-1:0] PIXEL_DIN,
  output logic             PAGE_SEL,
  output page_state_t      dbg_state
);

`ifdef FB_CLEAR_EN
  localparam page_state_t START_STATE = CLEAR;
`else
  localparam page_state_t START_STATE = DRAW;
`endif

  page_state_t      state, next_state;
  logic             vb_s1, vb_s2, vb_s3, vb_rise;
  logic             we_d, gnt_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic [PIX_W-1:0] din_d;

  assign vb_rise   = vb_s2 & ~vb_s3;
  assign dbg_state = state;

`ifdef FB_CLEAR_EN
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           clr_last, clr_en;

  assign clr_en = (state == CLEAR);

  fb_sweep_counter u_sweep (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .en   (clr_en),
    .x    (cx),
    .y    (cy),
    .last (clr_last)
  );
`else
  logic [PIX_W-1:0] unused_bg;
  assign unused_bg = BG_COLOR;
`endif

  // Handshake: a draw write transfers in every cycle where DRAW_REQ and
  // DRAW_GNT are both high; there is no other backpressure and no queueing.
  always_comb begin
    next_state = state;
    we_d       = 1'b0;
    x_d        = PIXEL_X;
    y_d        = PIXEL_Y;
    din_d      = PIXEL_DIN;
    case (state)
`ifdef FB_CLEAR_EN
      CLEAR: begin
        we_d  = 1'b1;
        x_d   = cx;
        y_d   = cy;
        din_d = BG_COLOR;
        if (clr_last) next_state = DRAW;
      end
`else
      CLEAR: next_state = DRAW;
`endif
      DRAW: begin
        if (DRAW_REQ && DRAW_GNT && in_screen(DRAW_X, DRAW_Y)) begin
          we_d  = 1'b1;
          x_d   = DRAW_X;
          y_d   = DRAW_Y;
          din_d = DRAW_PIXEL;
        end
        if (DRAW_DONE) next_state = WAIT_VB;
      end
      WAIT_VB: if (vb_rise) next_state = FLIP;
      FLIP:    next_state = START_STATE;
      default: next_state = START_STATE;
    endcase
  end

  // The grant lags DRAW entry by one cycle so it never overlaps the final
  // clear write or the FRAME_START pulse.
  assign gnt_d = (state == DRAW) && (next_state == DRAW);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= START_STATE;
      vb_s1       <= 1'b0;
      vb_s2       <= 1'b0;
      vb_s3       <= 1'b0;
      DRAW_GNT    <= 1'b0;
      FRAME_START <= 1'b0;
      WE          <= 1'b0;
      PIXEL_X     <= '0;
      PIXEL_Y     <= '0;
      PIXEL_DIN   <= '0;
      PAGE_SEL    <= 1'b0;
    end else begin
      state       <= next_state;
      vb_s1       <= VBLANK;
      vb_s2       <= vb_s1;
      vb_s3       <= vb_s2;
      DRAW_GNT    <= gnt_d;
      FRAME_START <= (state == FLIP);
      WE          <= we_d;
      PIXEL_X     <= x_d;
      PIXEL_Y     <= y_d;
      PIXEL_DIN   <= din_d;
      if (state == FLIP) PAGE_SEL <= ~PAGE_SEL;
    end
  end

endmodule

// File: tb/tb_page_flip_ctrl.sv
// Bench for page_flip_ctrl: clear sweep (when FB_CLEAR_EN), directed and random
// draw writes against a rule-level model, done/vblank flip timing, mid-run reset.
module tb_page_flip_ctrl;
  import fb_pkg::*;

  localparam logic [PIX_W-1:0] BG = 8'h2A;
  localparam int W = X_W + Y_W + PIX_W;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             vblank     = 1'b0;
  logic             draw_req   = 1'b0;
  logic             draw_done  = 1'b0;
  logic [X_W-1:0]   draw_x     = '0;
  logic [Y_W-1:0]   draw_y     = '0;
  logic [PIX_W-1:0] draw_pixel = '0;
  logic             draw_gnt, frame_start, we, page_sel;
  logic [X_W-1:0]   pixel_x;
  logic [Y_W-1:0]   pixel_y;
  logic [PIX_W-1:0] pixel_din;
  page_state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic exp_page = 1'b0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #10 clk = ~clk;

  page_flip_ctrl #(.BG_COLOR(BG)) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .VBLANK      (vblank),
    .DRAW_REQ    (draw_req),
    .DRAW_X      (draw_x),
    .DRAW_Y      (draw_y),
    .DRAW_PIXEL  (draw_pixel),
    .DRAW_DONE   (draw_done),
    .DRAW_GNT    (draw_gnt),
    .FRAME_START (frame_start),
    .WE          (we),
    .PIXEL_X     (pixel_x),
    .PIXEL_Y     (pixel_y),
    .PIXEL_DIN   (pixel_din),
    .PAGE_SEL    (page_sel),
    .dbg_state   (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblank = 1'b0; draw_req = 1'b0; draw_done = 1'b0;
    repeat (3) step();
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", we); end
    checks++;
    if ({pixel_x, pixel_y, pixel_din} !== {W{1'b0}}) begin
      errors++; $display("FAIL reset_pixel got x=%0d y=%0d d=%0h want 0", pixel_x, pixel_y, pixel_din);
    end
    checks++;
    if (draw_gnt !== 1'b0 || frame_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got gnt=%0b fs=%0b want 0 0", draw_gnt, frame_start);
    end
    checks++;
    if (page_sel !== 1'b0) begin errors++; $display("FAIL reset_page got %0b want 0", page_sel); end
    rst = 1'b0;
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear_sweep();
    int bad;
    int first_bad;
    bad = 0; first_bad = -1;
    for (int i = 0; i < SCREEN_W * SCREEN_H; i++) begin
      step();
      if (we !== 1'b1 || pixel_x !== X_W'(i % SCREEN_W) || pixel_y !== Y_W'(i / SCREEN_W) ||
          pixel_din !== BG || draw_gnt !== 1'b0 || page_sel !== 1'b0) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL clear_sweep got %0d bad steps (first %0d) want 0", bad, first_bad);
    end
    step();
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL clear_end_we got %0b want 0", we); end
    checks++;
    if (draw_gnt !== 1'b1) begin errors++; $display("FAIL clear_gnt_rise got %0b want 1", draw_gnt); end
  endtask
`else
  task automatic test_no_clear_start();
    step();
    checks++;
    if (draw_gnt !== 1'b1) begin errors++; $display("FAIL start_gnt got %0b want 1", draw_gnt); end
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL start_we got %0b want 0", we); end
  endtask
`endif

  task automatic test_draw_directed();
    draw_req = 1'b1; draw_x = 9'd10; draw_y = 9'd20; draw_pixel = 8'h55;
    step();
    draw_x = 9'd320; draw_y = 9'd5; draw_pixel = 8'h11;
    checks++;
    if (we !== 1'b1 || pixel_x !== 9'd10 || pixel_y !== 9'd20 || pixel_din !== 8'h55) begin
      errors++;
      $display("FAIL draw_inrange got we=%0b (%0d,%0d,%0h) want 1 (10,20,55)", we, pixel_x, pixel_y, pixel_din);
    end
    step();
    draw_req = 1'b0;
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL draw_outrange got we=%0b want 0", we); end
  endtask

  task automatic test_draw_random();
    int req, x, y, p;
    logic [W-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      req = $urandom_range(0, 1);
      x   = $urandom_range(0, 335);
      y   = $urandom_range(0, 255);
      p   = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      draw_req = (req != 0); draw_x = X_W'(x); draw_y = Y_W'(y); draw_pixel = PIX_W'(p);
      if (req != 0 && x < SCREEN_W && y < SCREEN_H) exp_q.push_back({X_W'(x), Y_W'(y), PIX_W'(p)});
      step();
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (we !== 1'b1 || {pixel_x, pixel_y, pixel_din} !== exp) begin
          errors++;
          $display("FAIL draw_write got we=%0b %0h want 1 %0h", we, {pixel_x, pixel_y, pixel_din}, exp);
        end
      end else begin
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL draw_drop got we=%0b want 0", we); end
      end
      checks++;
      if (draw_gnt !== 1'b1 || frame_start !== 1'b0 || page_sel !== exp_page) begin
        errors++;
        $display("FAIL draw_ctrl got gnt=%0b fs=%0b pg=%0b want 1 0 %0b", draw_gnt, frame_start, page_sel, exp_page);
      end
    end
    draw_req = 1'b0;
  endtask

  task automatic test_done_and_flip();
    int bad;
    vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (we !== 1'b0 || draw_gnt !== 1'b1) begin
        errors++; $display("FAIL draw_idle got we=%0b gnt=%0b want 0 1", we, draw_gnt);
      end
    end
    draw_req = 1'b1; draw_x = 9'd5; draw_y = 9'd5; draw_pixel = 8'h77; draw_done = 1'b1;
    step();
    draw_req = 1'b0; draw_done = 1'b0;
    checks++;
    if (we !== 1'b1 || pixel_x !== 9'd5 || pixel_y !== 9'd5 || pixel_din !== 8'h77) begin
      errors++;
      $display("FAIL done_write got we=%0b (%0d,%0d,%0h) want 1 (5,5,77)", we, pixel_x, pixel_y, pixel_din);
    end
    checks++;
    if (draw_gnt !== 1'b0) begin errors++; $display("FAIL done_gnt_fall got %0b want 0", draw_gnt); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (we !== 1'b0 || draw_gnt !== 1'b0 || frame_start !== 1'b0 || page_sel !== exp_page) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wait_vb_hold got %0d bad cycles want 0", bad); end
    vblank = 1'b0;
    repeat (5) step();
    vblank = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 4) begin
        checks++;
        if (frame_start !== 1'b0 || page_sel !== exp_page) begin
          errors++; $display("FAIL flip_early k=%0d got fs=%0b pg=%0b want 0 %0b", k, frame_start, page_sel, exp_page);
        end
      end else if (k == 4) begin
        exp_page = ~exp_page;
        checks++;
        if (frame_start !== 1'b1 || page_sel !== exp_page) begin
          errors++; $display("FAIL flip_edge got fs=%0b pg=%0b want 1 %0b", frame_start, page_sel, exp_page);
        end
        checks++;
        if (draw_gnt !== 1'b0) begin errors++; $display("FAIL flip_gnt got %0b want 0", draw_gnt); end
      end else begin
        checks++;
        if (frame_start !== 1'b0 || page_sel !== exp_page) begin
          errors++; $display("FAIL flip_pulse got fs=%0b pg=%0b want 0 %0b", frame_start, page_sel, exp_page);
        end
`ifdef FB_CLEAR_EN
        checks++;
        if (we !== 1'b1 || pixel_x !== 9'd0 || pixel_y !== 9'd0 || pixel_din !== BG || draw_gnt !== 1'b0) begin
          errors++;
          $display("FAIL clear_restart got we=%0b (%0d,%0d,%0h) gnt=%0b want 1 (0,0,2a) 0", we, pixel_x, pixel_y, pixel_din, draw_gnt);
        end
`else
        checks++;
        if (draw_gnt !== 1'b1 || we !== 1'b0) begin
          errors++; $display("FAIL regrant got gnt=%0b we=%0b want 1 0", draw_gnt, we);
        end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
`ifdef FB_CLEAR_EN
    for (int i = 1; i <= 5000; i++) begin
      step();
      if (we !== 1'b1 || pixel_x !== X_W'(i % SCREEN_W) || pixel_y !== Y_W'(i / SCREEN_W) || pixel_din !== BG) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clear_second got %0d bad steps want 0", bad); end
`endif
    rst = 1'b1;
    exp_page = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || {pixel_x, pixel_y, pixel_din} !== {W{1'b0}} || draw_gnt !== 1'b0 ||
        frame_start !== 1'b0 || page_sel !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got we=%0b x=%0d y=%0d d=%0h gnt=%0b fs=%0b pg=%0b want all 0",
               we, pixel_x, pixel_y, pixel_din, draw_gnt, frame_start, page_sel);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
`ifdef FB_CLEAR_EN
    checks++;
    if (we !== 1'b1 || pixel_x !== 9'd0 || pixel_y !== 9'd0 || page_sel !== 1'b0) begin
      errors++; $display("FAIL midreset_restart got we=%0b (%0d,%0d) pg=%0b want 1 (0,0) 0", we, pixel_x, pixel_y, page_sel);
    end
    step();
    checks++;
    if (we !== 1'b1 || pixel_x !== 9'd1 || pixel_y !== 9'd0 || pixel_din !== BG) begin
      errors++; $display("FAIL midreset_second got we=%0b (%0d,%0d,%0h) want 1 (1,0,2a)", we, pixel_x, pixel_y, pixel_din);
    end
`else
    checks++;
    if (draw_gnt !== 1'b1 || we !== 1'b0 || page_sel !== 1'b0) begin
      errors++; $display("FAIL midreset_restart got gnt=%0b we=%0b pg=%0b want 1 0 0", draw_gnt, we, page_sel);
    end
`endif
  endtask

  initial begin
    test_reset();
`ifdef FB_CLEAR_EN
    test_clear_sweep();
`else
    test_no_clear_start();
`endif
    test_draw_directed();
    test_draw_random();
    test_done_and_flip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_flip_ctrl.md
# page_flip_ctrl

Sequencing controller for the double-buffered frame buffer. It owns PAGE_SEL and the single write port (WE, PIXEL_X, PIXEL_Y, PIXEL_DIN). Each frame it clears the back page to a background colour, grants the draw engine write access, then waits for vertical blank and flips pages. It sits between the object/draw engine and frame_buffer, in the CLOCK_50 domain.

## Interface
- BG_COLOR, 8'h00, paletted colour written to every back-page pixel during clear
- CLOCK_50  in  1  system clock; the only clock of the block
- RESET  in  1  asynchronous, active-high reset
- VBLANK  in  1  vertical-blank level from the VGA controller; asynchronous to CLOCK_50; synchronised internally with 2 flops
- DRAW_REQ  in  1  draw engine has a pixel write this cycle
- DRAW_X  in  9  target x
- DRAW_Y  in  9  target y
- DRAW_PIXEL  in  8  pixel data
- DRAW_DONE  in  1  single-cycle pulse; the draw engine has finished the frame
- DRAW_GNT  out  1  write port is granted to the draw engine
- FRAME_START  out  1  single-cycle pulse on every page flip
- WE  out  1  to frame_buffer WE
- PIXEL_X  out  9  to frame_buffer PIXEL_X
- PIXEL_Y  out  9  to frame_buffer PIXEL_Y
- PIXEL_DIN  out  8  to frame_buffer PIXEL_DIN
- PAGE_SEL  out  1  0: page 0 displayed, page 1 written; 1: page 1 displayed, page 0 written

## Operation
- States: CLEAR, DRAW, WAIT_VB, FLIP.
- **CLEAR:** sweep counters cx (0..319) and cy (0..239). One write per cycle: WE=1, data=BG_COLOR. cx wraps 319→0 with cy+1. After the (319,239) write, go to DRAW; counters return to 0. DRAW_GNT=0.
- **DRAW:** DRAW_GNT=1. A transfer occurs when DRAW_REQ&&DRAW_GNT.
  - The write is forwarded only if DRAW_X<320 and DRAW_Y<240. Out-of-range writes are dropped (WE=0).
  - DRAW_DONE moves the block to WAIT_VB. If DRAW_REQ is asserted in the same cycle, that write is still performed.
- **WAIT_VB:** DRAW_GNT=0, WE=0. A rising edge of the synchronised VBLANK moves the block to FLIP.
  - VBLANK edges seen in CLEAR or DRAW are ignored. Only an edge detected in WAIT_VB flips the pages.
- **FLIP:** one cycle. Toggle PAGE_SEL, pulse FRAME_START, go to CLEAR.
- DRAW_DONE is ignored outside DRAW. DRAW_REQ is ignored when DRAW_GNT=0; there is no stall or queue, and the engine must hold the request until granted.
- Reset values:
  - state=CLEAR, PAGE_SEL=0, cx=cy=0
  - WE=0, PIXEL_X=PIXEL_Y=0, PIXEL_DIN=0
  - DRAW_GNT=0, FRAME_START=0, VBLANK sync flops=0
- Reset mid-operation aborts any clear or draw. The block restarts CLEAR at (0,0) with PAGE_SEL=0.

## Timing
- All outputs are registered.
- Write latency: a DRAW transfer in cycle n, or a clear step in cycle n, drives WE, PIXEL_X/Y and PIXEL_DIN in cycle n+1 for exactly one cycle.
- DRAW_GNT rises the cycle after the final clear write is issued. It falls the cycle after DRAW_DONE is sampled.
- Clear occupies exactly 76800 consecutive WE cycles.
- VBLANK to flip: a rising edge reaches the edge detector after 2 sync cycles. The state enters FLIP on the next edge. PAGE_SEL and FRAME_START change in the cycle following FLIP entry, i.e. 4 cycles after the VBLANK rising edge at the input, with no intermediate stalls.
- PAGE_SEL never changes while WE=1 is in flight: the last write of DRAW has retired before FLIP.

## Configuration
- Macro: FB_CLEAR_EN.
- Defined: behaviour as above, with CLEAR after reset and after every FLIP.
- Undefined: the CLEAR state, sweep counters and BG_COLOR usage are compiled out. Reset and FLIP go directly to DRAW, so DRAW_GNT=1 in the first cycle after reset release. The back page keeps the stale contents of two frames earlier.

## Structure
- Shared package fb_pkg holds:
  - SCREEN_W=320 and SCREEN_H=240
  - the coordinate widths (9-bit x/y, 8-bit pixel)
  - the state enum page_state_t
- Sub-module fb_sweep_counter: x/y raster counter with enable, wrap and last-pixel flag. It is instantiated only under FB_CLEAR_EN.

## Test plan
- Reset release, FB_CLEAR_EN defined, BG_COLOR=8'h2A → 76800 consecutive WE cycles. The first write is at (0,0) and the last at (319,239), all data 8'h2A. DRAW_GNT=1 on the following cycle, PAGE_SEL=0.
- In DRAW: REQ with (10,20,8'h55) then (320,5,8'h11) → WE=1 at (10,20) with 8'h55 one cycle later; no WE for the out-of-range write.
- DRAW_DONE with a simultaneous REQ at (5,5) → the write appears, DRAW_GNT falls. A VBLANK edge 100 cycles later → PAGE_SEL=1 and a FRAME_START pulse 4 cycles after the edge, then CLEAR restarts.
- VBLANK edge during DRAW, then DRAW_DONE → no flip until the next VBLANK edge.
- RESET asserted at clear step 5000 → outputs immediately at reset values. After release, the clear restarts from (0,0) with PAGE_SEL=0.
- FB_CLEAR_EN undefined → DRAW_GNT=1 the first cycle after reset, no clear writes ever. After a flip, DRAW_GNT returns the cycle after FRAME_START.
